// File: rtl/pc_vector_seq.sv
// Interrupt/reset vector sequencer: arbitrates RESET/NMI/BRK/IRQ and loads the PC from the vector.
// Optional input synchronisers on n_nmi/n_irq when PC_VECTOR_SYNC_EN is defined.
module pc_vector_seq #(
    parameter int              ADDR_N  = 16,
    parameter int              DATA_N  = 8,
    parameter logic [ADDR_N-1:0] VEC_NMI = 16'hfffa,
    parameter logic [ADDR_N-1:0] VEC_RST = 16'hfffc,
    parameter logic [ADDR_N-1:0] VEC_IRQ = 16'hfffe
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              n_nmi,
    input  logic              n_irq,
    input  logic              i_flag,
    input  logic              brk,
    input  logic              ready,
    input  logic [DATA_N-1:0] data_in,
    output logic [ADDR_N-1:0] addr_out,
    output logic [DATA_N-1:0] pc_data,
    output logic              pc_wel,
    output logic              pc_weh,
    output logic              busy,
    output logic              done,
    output logic [1:0]        int_src,
    output logic              brk_ack
);
    // state   | meaning
    // IDLE    | waiting for a pending source at an instruction boundary
    // FETCH_L | reading vector low byte into PC low
    // FETCH_H | reading vector high byte into PC high
    // DONE    | one-cycle completion pulse, bus released
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH_L, ST_FETCH_H, ST_DONE} state_t;

    state_t            state, state_nxt;
    logic              nmi_s, irq_s, nmi_prev, nmi_fall;
    logic              rst_pend, nmi_pend;
    logic [ADDR_N-1:0] vec;
    logic [1:0]        int_src_q;
    logic              brk_ack_q;
    logic              arb_en, win_rst, win_nmi, win_brk, win_irq, win_any;
    logic              addr_en;
    logic [ADDR_N-1:0] addr_drv;

`ifdef PC_VECTOR_SYNC_EN
    logic [1:0] nmi_sync, irq_sync;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            nmi_sync <= 2'b11;
            irq_sync <= 2'b11;
        end else begin
            nmi_sync <= {nmi_sync[0], n_nmi};
            irq_sync <= {irq_sync[0], n_irq};
        end
    end

    assign nmi_s = nmi_sync[1];
    assign irq_s = irq_sync[1];
`else
    assign nmi_s = n_nmi;
    assign irq_s = n_irq;
`endif

    assign nmi_fall = nmi_prev & ~nmi_s;

    // Priority RST > NMI > BRK > IRQ; a pending reset arbitrates without waiting for ready.
    assign arb_en  = (state == ST_IDLE) && (rst_pend || ready);
    assign win_rst = arb_en && rst_pend;
    assign win_nmi = arb_en && !rst_pend && nmi_pend;
    assign win_brk = arb_en && !rst_pend && !nmi_pend && brk;
    assign win_irq = arb_en && !rst_pend && !nmi_pend && !brk && !irq_s && !i_flag;
    assign win_any = win_rst || win_nmi || win_brk || win_irq;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            nmi_prev  <= 1'b1;
            rst_pend  <= 1'b1;
            nmi_pend  <= 1'b0;
            vec       <= '0;
            int_src_q <= 2'd0;
            brk_ack_q <= 1'b0;
        end else begin
            nmi_prev  <= nmi_s;
            rst_pend  <= rst_pend & ~win_rst;
            // A new edge wins over the clear so an NMI arriving at entry is not lost.
            nmi_pend  <= nmi_fall | (nmi_pend & ~win_nmi);
            brk_ack_q <= win_brk;
            if (win_rst) begin
                vec       <= VEC_RST;
                int_src_q <= 2'd1;
            end else if (win_nmi) begin
                vec       <= VEC_NMI;
                int_src_q <= 2'd2;
            end else if (win_brk || win_irq) begin
                vec       <= VEC_IRQ;
                int_src_q <= 2'd3;
            end else if (state == ST_DONE) begin
                int_src_q <= 2'd0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (win_any) state_nxt = ST_FETCH_L;
            ST_FETCH_L: state_nxt = ST_FETCH_H;
            ST_FETCH_H: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_en  = 1'b0;
        addr_drv = '0;
        pc_data  = '0;
        pc_wel   = 1'b0;
        pc_weh   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_FETCH_L: begin
                addr_en  = 1'b1;
                addr_drv = vec;
                pc_data  = data_in;
                pc_wel   = 1'b1;
                busy     = 1'b1;
            end
            ST_FETCH_H: begin
                addr_en  = 1'b1;
                addr_drv = vec + 1'b1;
                pc_data  = data_in;
                pc_weh   = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign addr_out = addr_en ? addr_drv : 'z;
    assign int_src  = int_src_q;
    assign brk_ack  = brk_ack_q;

endmodule
